pl_id_scoreboard: RTL and testbench

- Parametrised register-hazard scoreboard for the ID stage; the next-generation replacement for fixed per-stage rd-compare interlock logic (erd/mrd, e1n..e3n).
- Each destination register has a busy bit and a latency countdown. Multi-cycle and variable-latency producers (divider, FPU, loads) issue into it.
- ID source operands are checked against it, producing per-source stall/forward indications for any source count.
- Sits beside pl_id_cu; the control unit gates wpcir with stall.

---
 rtl/pl_id_scoreboard.sv | 89 ++++++++
 tb/tb_pl_id_scoreboard.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pl_id_scoreboard.sv
// Register-hazard scoreboard for the ID stage: a per-register busy bit and latency
// countdown. Produces per-source stall/forward indications plus WAW and structural stalls.
module pl_id_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NSRC     = 3,
  parameter int LATW     = 3,
  parameter int MAX_OUT  = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           clrn,
  input  logic                           flush,
  input  logic                           iss_v,
  input  logic [AW-1:0]                  iss_rd,
  input  logic [LATW-1:0]                iss_lat,
  input  logic [NSRC-1:0]                src_v,
  input  logic [NSRC*AW-1:0]             src_rn,
  input  logic                           cmp_v,
  input  logic [AW-1:0]                  cmp_rd,
  output logic                           stall,
  output logic [NSRC-1:0]                src_fwd,
  output logic [NSRC-1:0]                src_haz,
  output logic [NREG-1:0]                busy_vec,
  output logic [$clog2(MAX_OUT+1)-1:0]   n_out
);
  localparam int NW = $clog2(MAX_OUT+1);
  localparam int PW = $clog2(NREG+1);
  localparam bit ZR = (ZERO_REG != 0);

  logic [NREG-1:0]           busy_q, busy_d;
  logic [NREG-1:0][LATW-1:0] cnt_q, cnt_d;
  logic [NW-1:0]             nout_q, nout_d;
  logic [PW-1:0]             pc;
  logic [NSRC-1:0]           hit;
  logic                      waw, full, acc, cmp_ok;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] rn;
    assign rn         = src_rn[i*AW +: AW];
    assign hit[i]     = src_v[i] & busy_q[rn] & ~(ZR & (rn == '0));
    assign src_haz[i] = hit[i] & (cnt_q[rn] != '0);
    assign src_fwd[i] = hit[i] & (cnt_q[rn] == '0);
  end

  // An older, longer-latency result must not land after a newer one to the same rd.
  assign waw  = iss_v & busy_q[iss_rd] & (cnt_q[iss_rd] > iss_lat);
  // A same-cycle completion of some other busy register frees the slot we need.
  assign full = iss_v & (nout_q == NW'(MAX_OUT)) & ~busy_q[iss_rd]
              & ~(cmp_v & (cmp_rd != iss_rd) & busy_q[cmp_rd]);
  assign stall  = (|src_haz) | waw | full;
  assign acc    = iss_v & ~stall & ~flush & ~(ZR & (iss_rd == '0));
  assign cmp_ok = cmp_v & ~(ZR & (cmp_rd == '0));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    pc     = '0;
    for (int r = 0; r < NREG; r++)
      if (busy_q[r] && cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LATW'(1);
    if (cmp_ok) busy_d[cmp_rd] = 1'b0;
    // Issue wins over a same-cycle completion and over the decrement.
    if (acc) begin
      busy_d[iss_rd] = 1'b1;
      cnt_d[iss_rd]  = iss_lat;
    end
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end
    for (int r = 0; r < NREG; r++) pc = pc + PW'(busy_d[r]);
    nout_d = NW'(pc);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      busy_q <= '0;
      cnt_q  <= '0;
      nout_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      nout_q <= nout_d;
    end
  end

  assign busy_vec = busy_q;
  assign n_out    = nout_q;
endmodule

// File: tb/tb_pl_id_scoreboard.sv
// Directed bench for pl_id_scoreboard: expectations queued when stimulus is driven,
// popped and compared against an integer-file and an FP-file instance.
module tb_pl_id_scoreboard;
  localparam int NREG = 32, AW = 5, NSRC = 3, LATW = 3, MAX_OUT = 4;
  localparam int NW = $clog2(MAX_OUT+1);

  logic clk = 1'b0;
  logic clrn, flush, iss_v, cmp_v;
  logic [AW-1:0] iss_rd, cmp_rd;
  logic [LATW-1:0] iss_lat;
  logic [NSRC-1:0] src_v;
  logic [NSRC*AW-1:0] src_rn;
  logic stall, fp_stall;
  logic [NSRC-1:0] src_fwd, src_haz, fp_fwd, fp_haz;
  logic [NREG-1:0] busy_vec, fp_busy;
  logic [NW-1:0] n_out, fp_nout;

  pl_id_scoreboard #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .LATW(LATW), .MAX_OUT(MAX_OUT), .ZERO_REG(1)) u_dut (
    .clk(clk), .clrn(clrn), .flush(flush), .iss_v(iss_v), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .src_v(src_v), .src_rn(src_rn), .cmp_v(cmp_v), .cmp_rd(cmp_rd), .stall(stall),
    .src_fwd(src_fwd), .src_haz(src_haz), .busy_vec(busy_vec), .n_out(n_out));

  pl_id_scoreboard #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .LATW(LATW), .MAX_OUT(MAX_OUT), .ZERO_REG(0)) u_fp (
    .clk(clk), .clrn(clrn), .flush(flush), .iss_v(iss_v), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .src_v(src_v), .src_rn(src_rn), .cmp_v(cmp_v), .cmp_rd(cmp_rd), .stall(fp_stall),
    .src_fwd(fp_fwd), .src_haz(fp_haz), .busy_vec(fp_busy), .n_out(fp_nout));

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic stall;
    logic [2:0] fwd, haz;
    logic [31:0] busy;
    logic [NW-1:0] nout;
    bit fpc;
    logic [2:0] fphaz;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic iv, input logic [4:0] rd, input logic [2:0] lat,
                     input logic [2:0] sv, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [4:0] r2, input logic cv, input logic [4:0] crd,
                     input logic fl);
    iss_v = iv; iss_rd = rd; iss_lat = lat;
    src_v = sv; src_rn = {r2, r1, r0};
    cmp_v = cv; cmp_rd = crd; flush = fl;
  endtask

  task automatic push_exp(input string tag, input logic st, input logic [2:0] fw,
                          input logic [2:0] hz, input logic [31:0] bz, input logic [NW-1:0] no,
                          input bit fpc = 0, input logic [2:0] fph = 3'b000);
    exp_t e;
    e.tag = tag; e.stall = st; e.fwd = fw; e.haz = hz; e.busy = bz; e.nout = no;
    e.fpc = fpc; e.fphaz = fph;
    sb.push_back(e);
  endtask

  // Combinational outputs sampled 1 time unit before the edge, registered ones 1 after.
  task automatic cyc();
    exp_t e;
    e = sb.pop_front();
    #4;
    check({e.tag, "/stall"}, 32'(stall), 32'(e.stall));
    check({e.tag, "/fwd"}, 32'(src_fwd), 32'(e.fwd));
    check({e.tag, "/haz"}, 32'(src_haz), 32'(e.haz));
    if (e.fpc) check({e.tag, "/fphaz"}, 32'(fp_haz), 32'(e.fphaz));
    @(posedge clk);
    #1;
    check({e.tag, "/busy"}, busy_vec, e.busy);
    check({e.tag, "/nout"}, 32'(n_out), 32'(e.nout));
    @(negedge clk);
  endtask

  initial begin
    clrn = 1'b0;
    drv(1, 5, 3, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    // reset held with an issue pending
    for (int i = 0; i < 2; i++) begin
      push_exp("reset", 0, 0, 0, 0, 0);
      cyc();
    end
    clrn = 1'b1;

    // latency countdown, lat=3
    drv(1, 7, 3, 0, 0, 0, 0, 0, 0, 0); push_exp("lat_iss", 0, 0, 0, 32'h80, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 3'b001, 7, 0, 0, 0, 0, 0); push_exp("lat_haz", 1, 0, 3'b001, 32'h80, 1); cyc();
    end
    drv(0, 0, 0, 3'b101, 7, 7, 7, 0, 0, 0); push_exp("lat_fwd", 0, 3'b101, 0, 32'h80, 1); cyc();
    drv(0, 0, 0, 3'b001, 7, 0, 0, 1, 7, 0); push_exp("lat_cmp", 0, 3'b001, 0, 0, 0); cyc();
    drv(0, 0, 0, 3'b001, 7, 0, 0, 0, 0, 0); push_exp("lat_done", 0, 0, 0, 0, 0); cyc();

    // WAW: rd4 lat6 then rd4 lat1 waits while cnt (6..2) exceeds 1
    drv(1, 4, 6, 0, 0, 0, 0, 0, 0, 0); push_exp("waw_iss", 0, 0, 0, 32'h10, 1); cyc();
    for (int i = 0; i < 5; i++) begin
      drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); push_exp("waw_stall", 1, 0, 0, 32'h10, 1); cyc();
    end
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); push_exp("waw_acc", 0, 0, 0, 32'h10, 1); cyc();
    drv(0, 0, 0, 3'b001, 4, 0, 0, 0, 0, 0); push_exp("waw_cnt1", 1, 0, 3'b001, 32'h10, 1); cyc();
    drv(0, 0, 0, 3'b001, 4, 0, 0, 1, 4, 0); push_exp("waw_fwd", 0, 3'b001, 0, 0, 0); cyc();

    // structural full and same-cycle relief
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("full_i1", 0, 0, 0, 32'h02, 1); cyc();
    drv(1, 2, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("full_i2", 0, 0, 0, 32'h06, 2); cyc();
    drv(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("full_i3", 0, 0, 0, 32'h0E, 3); cyc();
    drv(1, 4, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("full_i4", 0, 0, 0, 32'h1E, 4); cyc();
    drv(1, 9, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("full_stall", 1, 0, 0, 32'h1E, 4); cyc();
    drv(1, 9, 0, 0, 0, 0, 0, 1, 2, 0); push_exp("full_relief", 0, 0, 0, 32'h21A, 4); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); push_exp("clr_flush", 0, 0, 0, 0, 0); cyc();

    // flush beats a same-cycle issue; stall still reflects the hazard
    drv(1, 3, 5, 0, 0, 0, 0, 0, 0, 0); push_exp("fl_i3", 0, 0, 0, 32'h008, 1); cyc();
    drv(1, 10, 5, 0, 0, 0, 0, 0, 0, 0); push_exp("fl_i10", 0, 0, 0, 32'h408, 2); cyc();
    drv(1, 12, 2, 3'b001, 3, 0, 0, 0, 0, 1); push_exp("fl_flush", 1, 0, 3'b001, 0, 0); cyc();
    drv(0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0); push_exp("fl_after", 0, 0, 0, 0, 0); cyc();

    // zero register: integer file ignores rd0, FP file tracks it
    drv(1, 0, 2, 0, 0, 0, 0, 0, 0, 0); push_exp("zr_iss", 0, 0, 0, 0, 0, 1, 3'b000); cyc();
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0); push_exp("zr_haz", 0, 0, 0, 0, 0, 1, 3'b001); cyc();
    end
    drv(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0); push_exp("zr_fwd", 0, 0, 0, 0, 0, 1, 3'b000); cyc();
    check("zr_fp_fwd", 32'(fp_fwd), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
